// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator and its environment.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package apb_pkg;

    // PADDR carries word address bits [5:2]; data path is one 32-bit word.
    localparam int APB_AW = 4;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Interrupt controller register window (word offsets on PADDR[5:2]).
    localparam logic [APB_AW-1:0] IC_CTRL      = 4'h0;
    localparam logic [APB_AW-1:0] IC_PRIO0     = 4'h1;
    localparam logic [APB_AW-1:0] IC_PRIO1     = 4'h2;
    localparam logic [APB_AW-1:0] IC_PRIO2     = 4'h3;
    localparam logic [APB_AW-1:0] IC_PRIO3     = 4'h4;
    localparam logic [APB_AW-1:0] IC_MASK      = 4'h5;
    localparam logic [APB_AW-1:0] IC_SWSET     = 4'h6;
    localparam logic [APB_AW-1:0] IC_CLEAR     = 4'h7;
    localparam logic [APB_AW-1:0] IC_ENABLE    = 4'h8;
    localparam logic [APB_AW-1:0] IC_PENDING   = 4'h9;
    localparam logic [APB_AW-1:0] IC_ACTIVE_ID = 4'hA;
    localparam logic [APB_AW-1:0] IC_IRQ_STAT  = 4'hB;

endpackage

// File: rtl/apb_initiator_if.sv
// Bundle of the command stream, response stream and APB2 bus of the initiator.
// Latency: n/a (wiring only).
// Backpressure: cmd via cmd_valid/cmd_ready, rsp via rsp_valid/rsp_ready; APB has none.
interface apb_initiator_if;
    import apb_pkg::*;

    // command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [APB_AW-1:0] cmd_addr;
    logic [APB_DW-1:0] cmd_wdata;

    // response stream
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [APB_DW-1:0] rsp_rdata;

    logic              busy;

    // APB2 bus (no PREADY / PSLVERR)
    logic              PSEL;
    logic              PENABLE;
    logic [APB_AW-1:0] PADDR;
    logic              PWRITE;
    logic [APB_DW-1:0] PWDATA;
    logic [APB_DW-1:0] PRDATA;

    // The initiator itself.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy,
               PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    // Whatever surrounds it: command source, response sink and APB peripheral.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy,
               PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

endinterface

// File: rtl/apb_initiator.sv
// Single-outstanding APB2 master: cmd stream -> SETUP/ENABLE transfer -> rsp stream.
// Latency: cmd accept to rsp_valid 3 cycles; cmd-to-cmd 3 (BACK_TO_BACK=1) or 4 cycles.
// Backpressure: cmd_ready only in IDLE (or RESP while rsp is consumed); rsp held until rsp_ready.
// Ports: PCLK/PRESET (sync, active-high) plus bus (apb_initiator_if.master).
module apb_initiator
    import apb_pkg::*;
#(
    parameter bit BACK_TO_BACK = 1'b1
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_initiator_if.master bus
);

    apb_state_e        state_q,     state_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic [APB_AW-1:0] paddr_q,     paddr_d;
    logic              pwrite_q,    pwrite_d;
    logic [APB_DW-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              busy_q,      busy_d;

    logic cmd_ready;
    logic cmd_fire;

    // In RESP a new command may only be taken when the pending response
    // leaves in the same cycle, which keeps a single transfer outstanding.
    always_comb begin
        cmd_ready = 1'b0;
        if (!PRESET) begin
            if (state_q == IDLE)
                cmd_ready = 1'b1;
            else if (BACK_TO_BACK && (state_q == RESP) && bus.rsp_ready)
                cmd_ready = 1'b1;
        end
    end

    assign cmd_fire = bus.cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = SETUP;
                    psel_d  = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ENABLE;
                penable_d = 1'b1;
            end
            ENABLE: begin
                // PRDATA is only looked at on this edge.
                state_d     = RESP;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_write_d = pwrite_q;
                rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (cmd_fire) begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Address/data only change on acceptance, so they stay stable through
        // the transfer and keep their last value afterwards.
        if (cmd_fire) begin
            paddr_d  = bus.cmd_addr;
            pwrite_d = bus.cmd_write;
            pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;

endmodule
